// File: rtl/comparator_stream.sv
// ============================================================================
// Module   : comparator_stream
// Brief    : Streaming signed/unsigned magnitude comparator with a sticky
//            trip alarm on consecutive A > B results. Define
//            COMPARATOR_MINMAX_EN to add running min/max tracking of A.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module comparator_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int TRIP_COUNT = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_valid,
  output logic                              o_ready,
  input  logic [DATA_WIDTH-1:0]             i_a,
  input  logic [DATA_WIDTH-1:0]             i_b,
  input  logic                              i_signed,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic                              o_gt,
  output logic                              o_lt,
  output logic                              o_eq,
  output logic                              o_trip,
  output logic [$clog2(TRIP_COUNT+1)-1:0]   o_trip_cnt,
`ifdef COMPARATOR_MINMAX_EN
  output logic [DATA_WIDTH-1:0]             o_min,
  output logic [DATA_WIDTH-1:0]             o_max,
`endif
  input  logic                              i_clear
);

  localparam int c_cnt_w = $clog2(TRIP_COUNT+1);
  localparam logic [c_cnt_w-1:0] c_trip = c_cnt_w'(TRIP_COUNT);
  localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    TRIPPED = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
  logic                 r_valid, r_gt, r_lt, r_eq;
  logic                 w_accept, w_gt, w_eq;

  assign o_ready  = ~r_valid | i_ready;
  assign w_accept = i_valid & o_ready;
  assign w_eq     = (i_a == i_b);
  assign w_gt     = i_signed ? ($signed(i_a) > $signed(i_b)) : (i_a > i_b);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
      r_eq    <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_gt    <= w_gt;
      r_lt    <= ~w_gt & ~w_eq;
      r_eq    <= w_eq;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Clear overrides an accept in the same cycle: that sample is not counted.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (i_clear) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else if (w_accept) begin
      case (r_state)
        IDLE: begin
          if (w_gt) begin
            w_cnt_nxt   = c_one;
            w_state_nxt = (c_one == c_trip) ? TRIPPED : COUNT;
          end
        end
        COUNT: begin
          if (w_gt) begin
            w_cnt_nxt = r_cnt + c_one;
            if (r_cnt + c_one == c_trip) w_state_nxt = TRIPPED;
          end else begin
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
          end
        end
        default: begin
          w_state_nxt = r_state;
          w_cnt_nxt   = r_cnt;
        end
      endcase
    end
  end

  assign o_valid    = r_valid;
  assign o_gt       = r_gt;
  assign o_lt       = r_lt;
  assign o_eq       = r_eq;
  assign o_trip     = (r_state == TRIPPED);
  assign o_trip_cnt = r_cnt;

`ifdef COMPARATOR_MINMAX_EN
  logic                  r_first;
  logic [DATA_WIDTH-1:0] r_min, r_max;
  logic                  w_below_min, w_above_max;

  assign w_below_min = i_signed ? ($signed(i_a) < $signed(r_min)) : (i_a < r_min);
  assign w_above_max = i_signed ? ($signed(i_a) > $signed(r_max)) : (i_a > r_max);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_first <= 1'b1;
      r_min   <= '0;
      r_max   <= '0;
    end else if (i_clear) begin
      r_first <= 1'b1;
    end else if (w_accept) begin
      r_first <= 1'b0;
      if (r_first || w_below_min) r_min <= i_a;
      if (r_first || w_above_max) r_max <= i_a;
    end
  end

  assign o_min = r_min;
  assign o_max = r_max;
`endif

endmodule

`default_nettype wire

// File: tb/tb_comparator_stream.sv
// ============================================================================
// Module   : tb_comparator_stream
// Brief    : Directed self-checking bench for comparator_stream against a
//            cycle-level reference model plus hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_comparator_stream;

  localparam int DW = 8;
  localparam int TC = 4;
  localparam int CW = $clog2(TC+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0, i_ready = 1'b1, i_signed = 1'b0, i_clear = 1'b0;
  logic [DW-1:0] i_a = '0, i_b = '0;
  wire           o_ready, o_valid, o_gt, o_lt, o_eq, o_trip;
  wire  [CW-1:0] o_trip_cnt;
`ifdef COMPARATOR_MINMAX_EN
  wire  [DW-1:0] o_min, o_max;
`endif

  int cmp_cnt = 0;
  int err_cnt = 0;

  comparator_stream #(.DATA_WIDTH(DW), .TRIP_COUNT(TC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_signed(i_signed), .o_valid(o_valid),
    .i_ready(i_ready), .o_gt(o_gt), .o_lt(o_lt), .o_eq(o_eq),
    .o_trip(o_trip), .o_trip_cnt(o_trip_cnt),
`ifdef COMPARATOR_MINMAX_EN
    .o_min(o_min), .o_max(o_max),
`endif
    .i_clear(i_clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int as_int(input logic [DW-1:0] v, input logic s);
    return s ? int'($signed(v)) : int'({1'b0, v});
  endfunction

  // Reference model: transaction-level view of the result slot and trip run.
  logic m_valid = 1'b0, m_gt = 1'b0, m_lt = 1'b0, m_eq = 1'b0, m_trip = 1'b0;
  int   m_run = 0;

  always @(posedge clk or negedge rst_n) begin : p_model
    int  av, bv, run_n;
    logic acc, trip_n;
    if (!rst_n) begin
      m_valid <= 1'b0; m_gt <= 1'b0; m_lt <= 1'b0; m_eq <= 1'b0;
      m_trip  <= 1'b0; m_run <= 0;
    end else begin
      acc    = i_valid && (!m_valid || i_ready);
      av     = as_int(i_a, i_signed);
      bv     = as_int(i_b, i_signed);
      run_n  = m_run;
      trip_n = m_trip;
      if (acc) begin
        m_valid <= 1'b1;
        m_gt <= (av > bv); m_lt <= (av < bv); m_eq <= (av == bv);
      end else if (i_ready) begin
        m_valid <= 1'b0;
      end
      if (i_clear) begin
        run_n = 0; trip_n = 1'b0;
      end else if (acc && !m_trip) begin
        if (av > bv) begin
          run_n = m_run + 1;
          if (run_n >= TC) trip_n = 1'b1;
        end else begin
          run_n = 0;
        end
      end
      m_run  <= run_n;
      m_trip <= trip_n;
    end
  end

  always @(negedge clk) begin
    check("ready",    int'(o_ready),    int'(!m_valid || i_ready));
    check("valid",    int'(o_valid),    int'(m_valid));
    check("trip",     int'(o_trip),     int'(m_trip));
    check("trip_cnt", int'(o_trip_cnt), m_run);
    if (m_valid) begin
      check("gt", int'(o_gt), int'(m_gt));
      check("lt", int'(o_lt), int'(m_lt));
      check("eq", int'(o_eq), int'(m_eq));
    end
  end

  // Drive one pair (inputs change 2 time units after a rising edge).
  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s);
    int n = 0;
    i_valid = 1'b1; i_a = a; i_b = b; i_signed = s;
    while (!o_ready && n < 20) begin
      @(posedge clk); #2; n++;
    end
    if (n == 20) begin
      cmp_cnt++; err_cnt++;
      $display("FAIL accept_timeout: got ready=0 expected ready=1 within 20 cycles");
    end
    @(posedge clk); #2;
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1);
  end

  initial begin
    #3;
    check("rst_valid", int'(o_valid), 0);
    check("rst_ready", int'(o_ready), 1);
    check("rst_cnt",   int'(o_trip_cnt), 0);
    idle(2); rst_n = 1'b1; idle(1);

`ifdef COMPARATOR_MINMAX_EN
    send(8'd5, 8'd0, 1); send(8'hFD, 8'd0, 1); send(8'd12, 8'd0, 1); send(8'd0, 8'd0, 1);
    check("min_signed", int'(o_min), 8'hFD);
    check("max_signed", int'(o_max), 12);
    i_clear = 1'b1; idle(1); i_clear = 1'b0;
    send(8'd7, 8'd0, 1);
    check("min_after_clr", int'(o_min), 7);
    check("max_after_clr", int'(o_max), 7);
    i_clear = 1'b1; idle(1); i_clear = 1'b0;
`endif

    send(8'h80, 8'h7F, 1); check("lit_signed_lt", int'(o_lt), 1);
    send(8'h80, 8'h7F, 0); check("lit_unsigned_gt", int'(o_gt), 1);
    send(8'h55, 8'h55, 1); check("lit_eq", int'(o_eq), 1);

    begin
      int exp_cnt[8] = '{1, 2, 3, 0, 1, 2, 3, 4};
      for (int i = 0; i < 8; i++) begin
        if (i == 3) send(8'd9, 8'd9, 0);
        else        send(8'd10, 8'd5, 0);
        check("lit_trip_cnt", int'(o_trip_cnt), exp_cnt[i]);
        check("lit_trip", int'(o_trip), (i == 7) ? 1 : 0);
      end
    end
    send(8'd1, 8'd2, 0); send(8'd1, 8'd2, 0);
    check("lit_trip_sticky", int'(o_trip), 1);
    check("lit_cnt_sat", int'(o_trip_cnt), 4);

    i_clear = 1'b1; idle(1); i_clear = 1'b0;
    check("lit_clr_trip", int'(o_trip), 0);
    repeat (3) send(8'd20, 8'd3, 0);
    check("lit_cnt3", int'(o_trip_cnt), 3);
    i_clear = 1'b1; send(8'd20, 8'd3, 0); i_clear = 1'b0;
    check("lit_clr_acc_cnt", int'(o_trip_cnt), 0);
    check("lit_clr_acc_gt",  int'(o_gt), 1);

    idle(1); i_ready = 1'b0;
    send(8'd3, 8'd1, 0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("lit_bp_ready", int'(o_ready), 0);
      check("lit_bp_hold",  int'(o_gt), 1);
    end
    i_ready = 1'b1;
    send(8'd1, 8'd3, 0);
    check("lit_b2b_valid", int'(o_valid), 1);
    check("lit_b2b_lt",    int'(o_lt), 1);

    send(8'd7, 8'd2, 0); idle(3);
    check("lit_stall_cnt", int'(o_trip_cnt), 1);
    send(8'd7, 8'd2, 0);
    check("lit_stall_cnt2", int'(o_trip_cnt), 2);

    idle(1); i_ready = 1'b0;
    send(8'd9, 8'd2, 0);
    check("lit_pre_rst_cnt", int'(o_trip_cnt), 3);
    #2; rst_n = 1'b0; #1;
    check("lit_arst_valid", int'(o_valid), 0);
    check("lit_arst_gt",    int'(o_gt), 0);
    check("lit_arst_trip",  int'(o_trip), 0);
    check("lit_arst_cnt",   int'(o_trip_cnt), 0);
    check("lit_arst_ready", int'(o_ready), 1);
    i_ready = 1'b1;
    @(posedge clk); #2; rst_n = 1'b1;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/comparator_stream.md
Name: comparator_stream

Overview:
Streaming, parametrised magnitude comparator for the datapath compare stage.
- Accepts operand pairs over a valid/ready handshake and returns registered gt/lt/eq flags with one cycle of latency.
- Supports unsigned and two's-complement operands, selected per transaction.
- Contains a trip detector: a sticky alarm raised after TRIP_COUNT consecutive accepted "a > b" results.

Parameters:
DATA_WIDTH, 8, operand width in bits (>= 2)
TRIP_COUNT, 4, consecutive accepted gt results needed to raise o_trip (>= 1)

Ports:
i_clk  input  1  clock; all state updates on the rising edge
i_rst_n  input  1  asynchronous active-low reset
i_valid  input  1  operand pair valid
o_ready  output  1  block can accept an operand pair this cycle
i_a  input  DATA_WIDTH  operand A
i_b  input  DATA_WIDTH  operand B
i_signed  input  1  1 = compare as two's complement, 0 = unsigned; sampled with the operands
o_valid  output  1  result registers hold an unconsumed result
i_ready  input  1  downstream accepts the result
o_gt  output  1  A > B
o_lt  output  1  A < B
o_eq  output  1  A == B
o_trip  output  1  sticky trip alarm
o_trip_cnt  output  $clog2(TRIP_COUNT+1)  current consecutive-gt count
i_clear  input  1  synchronous clear of the trip FSM and counter

Behaviour:
- Reset (asynchronous, i_rst_n low): o_valid=0, o_gt=0, o_lt=0, o_eq=0, o_trip=0, o_trip_cnt=0, FSM in IDLE. The ready output is combinational, so o_ready=1 during reset.
- Clock and reset: single clock i_clk; reset i_rst_n is asynchronous assert, active-low. Deassertion is synchronised externally.
- Handshake:
  - Accept occurs when i_valid & o_ready. Output transfer occurs when o_valid & i_ready.
  - o_ready = ~o_valid | i_ready (combinational, one-entry pipeline). There is no combinational path from i_valid to o_ready.
  - On accept, the result registers load and o_valid=1 on the next cycle. Latency is 1 cycle.
  - On output transfer with no accept, o_valid drops to 0. On transfer with simultaneous accept, o_valid stays 1 with the new result.
  - o_gt, o_lt and o_eq hold their values while o_valid=1 and i_ready=0.
  - The upstream side must hold i_a, i_b, i_signed and i_valid stable until accepted.
- Compare:
  - Exactly one of gt, lt or eq is 1 for every loaded result.
  - i_signed=1 compares the MSB as the sign bit. Example with DATA_WIDTH=8: 0x80 < 0x7F signed, but 0x80 > 0x7F unsigned.
  - eq is independent of i_signed.
- Trip FSM (advances only on accept; counts the result being loaded):
  - IDLE (cnt=0): gt accept -> cnt=1; go to TRIPPED if TRIP_COUNT==1, else COUNT.
  - COUNT: gt accept -> cnt+1; on reaching TRIP_COUNT -> TRIPPED. lt/eq accept -> IDLE with cnt=0.
  - TRIPPED: o_trip=1; cnt saturates at TRIP_COUNT; further accepts have no effect. Exit only via i_clear or reset.
  - o_trip and o_trip_cnt update on the same edge that loads the result, so they are aligned with o_valid.
- i_clear:
  - Forces IDLE with cnt=0 and o_trip=0 on the next edge.
  - If an accept coincides with i_clear, the clear wins. The sample's result is still loaded and presented, but it is not counted.
  - i_clear does not affect o_valid or the result flags.
- Stalls: cycles without an accept leave the FSM and count unchanged. Non-consecutive gt results separated only by idle or stall cycles still count as consecutive.
- Reset mid-operation: any pending result is discarded (o_valid=0) and the FSM returns to IDLE immediately.

Optional Feature:
COMPARATOR_MINMAX_EN
- Defined:
  - Adds outputs o_min and o_max (DATA_WIDTH each), tracking the running minimum and maximum of accepted A operands.
  - Tracking uses the i_signed interpretation of each accepted sample.
  - Both reset to the first accepted sample after reset or i_clear. Internally, a "first" flag is set by reset or i_clear and cleared on the next accept.
  - o_min and o_max update on the accept edge.
- Undefined: the ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Reset with i_rst_n=0 mid-stream while o_valid=1 -> o_valid, o_gt, o_lt, o_eq, o_trip and o_trip_cnt all 0 immediately (asynchronous); o_ready=1.
- DATA_WIDTH=8: a=0x80, b=0x7F with i_signed=1 -> o_lt=1 one cycle later; same pair with i_signed=0 -> o_gt=1; a=b=0x55 -> o_eq=1.
- Backpressure: i_ready=0 for 3 cycles after a result -> o_ready=0, result held stable; on i_ready=1 with a new i_valid -> back-to-back transfer, o_valid stays 1.
- TRIP_COUNT=4: gt,gt,gt,eq,gt,gt,gt,gt -> o_trip_cnt goes 1,2,3,0,1,2,3,4 and o_trip=1 with the 8th result; further lt accepts leave o_trip=1 and cnt=4.
- i_clear asserted together with a gt accept while cnt=3 -> next cycle o_trip=0, cnt=0, and the gt result is presented on o_gt.
- With COMPARATOR_MINMAX_EN defined, signed samples 5, -3, 12, 0 -> o_min=-3 and o_max=12; after i_clear then sample 7 -> o_min=o_max=7.
